// File: rtl/sobel_scan_ctrl.sv
// sobel_scan_ctrl - raster-scan sequencer for the Sobel datapath.
//
// Walks every interior pixel of a W x H image. For each one it fetches the
// 3x3 neighbourhood into the window register file, pulses calc_start, waits
// for calc_done and then writes the result to the output buffer in raster order.
//
// Build option: SCAN_COL_REUSE_EN. When it is defined, a pixel that continues
// along the same row shifts the window left (win_shift) and fetches only the
// new right-hand column (slots 2,5,8). When it is undefined, every pixel
// fetches all nine slots and win_shift stays 0.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start, img_w, img_h      frame start and dimensions, latched in IDLE
//   rd_req/rd_addr/rd_ack    pixel memory read handshake
//   load_en, win_idx         write read data into window slot win_idx
//   win_shift                shift window one column left (reuse build only)
//   calc_start, calc_done    gradient compute handshake
//   wr_req/wr_addr/wr_ack    result buffer write handshake
//   busy, done               status: not idle / end-of-frame pulse
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start
// FETCH   | reading window slot k until rd_ack
// CALC    | calc_start on first cycle, then wait calc_done
// WRITE   | writing result until wr_ack
// ADVANCE | step col/row, decide next pixel or end of frame
// DONE    | one-cycle done pulse
module sobel_scan_ctrl #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  img_w,
  input  logic [CNT_W-1:0]  img_h,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  output logic              load_en,
  output logic [3:0]        win_idx,
  output logic              win_shift,
  output logic              calc_start,
  input  logic              calc_done,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ack,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CALC, S_WRITE, S_ADVANCE, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0]  C_ONE   = 1;
  localparam logic [CNT_W-1:0]  C_TWO   = 2;
  localparam logic [CNT_W-1:0]  C_THREE = 3;
  localparam logic [ADDR_W-1:0] A_ONE   = 1;
  localparam logic [ADDR_W-1:0] A_TWO   = 2;
  localparam logic [3:0]        K_LAST  = 4'd8;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  w_q, h_q, row_q, col_q;
  logic [3:0]        k_q;
  logic              calc_wait_q;  // set after the first CALC cycle
  logic              reuse_q;      // current pixel fetches only the new column

  logic              too_small, row_end, frame_end;
  logic [1:0]        win_dr, win_dc;
  logic [ADDR_W-1:0] rd_addr_calc, wr_addr_calc;

  assign too_small = (img_w < C_THREE) || (img_h < C_THREE);
  assign row_end   = (col_q == w_q - C_TWO);
  assign frame_end = row_end && (row_q == h_q - C_TWO);

  always_comb begin
    win_dr = 2'd0;
    win_dc = 2'd0;
    case (k_q)
      4'd0: begin win_dr = 2'd0; win_dc = 2'd0; end
      4'd1: begin win_dr = 2'd0; win_dc = 2'd1; end
      4'd2: begin win_dr = 2'd0; win_dc = 2'd2; end
      4'd3: begin win_dr = 2'd1; win_dc = 2'd0; end
      4'd4: begin win_dr = 2'd1; win_dc = 2'd1; end
      4'd5: begin win_dr = 2'd1; win_dc = 2'd2; end
      4'd6: begin win_dr = 2'd2; win_dc = 2'd0; end
      4'd7: begin win_dr = 2'd2; win_dc = 2'd1; end
      4'd8: begin win_dr = 2'd2; win_dc = 2'd2; end
      default: begin win_dr = 2'd0; win_dc = 2'd0; end
    endcase
  end

  // Unsigned arithmetic, wrapping modulo 2^ADDR_W.
  assign rd_addr_calc = (ADDR_W'(row_q) + ADDR_W'(win_dr) - A_ONE) * ADDR_W'(w_q)
                        + ADDR_W'(col_q) + ADDR_W'(win_dc) - A_ONE;
  assign wr_addr_calc = (ADDR_W'(row_q) - A_ONE) * (ADDR_W'(w_q) - A_TWO)
                        + ADDR_W'(col_q) - A_ONE;

  always_comb begin
    state_d    = state_q;
    rd_req     = 1'b0;
    rd_addr    = '0;
    load_en    = 1'b0;
    win_idx    = 4'd0;
    win_shift  = 1'b0;
    calc_start = 1'b0;
    wr_req     = 1'b0;
    wr_addr    = '0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) state_d = too_small ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        rd_req  = 1'b1;
        rd_addr = rd_addr_calc;
        win_idx = k_q;
        load_en = rd_ack;
        if (rd_ack && (k_q == K_LAST)) state_d = S_CALC;
      end
      S_CALC: begin
        calc_start = !calc_wait_q;
        if (calc_wait_q && calc_done) state_d = S_WRITE;
      end
      S_WRITE: begin
        wr_req  = 1'b1;
        wr_addr = wr_addr_calc;
        if (wr_ack) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
`ifdef SCAN_COL_REUSE_EN
        win_shift = !row_end;
`endif
        state_d = frame_end ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      k_q         <= 4'd0;
      calc_wait_q <= 1'b0;
      reuse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      calc_wait_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            w_q     <= img_w;
            h_q     <= img_h;
            row_q   <= C_ONE;
            col_q   <= C_ONE;
            k_q     <= 4'd0;
            reuse_q <= 1'b0;
          end
        end
        S_FETCH: begin
          // Both fetch orders end on slot 8, which hands over to CALC.
          if (rd_ack) k_q <= reuse_q ? k_q + 4'd3 : k_q + 4'd1;
        end
        S_CALC: calc_wait_q <= 1'b1;
        S_ADVANCE: begin
          if (row_end) begin
            col_q   <= C_ONE;
            row_q   <= row_q + C_ONE;
            k_q     <= 4'd0;
            reuse_q <= 1'b0;
          end else begin
            col_q <= col_q + C_ONE;
`ifdef SCAN_COL_REUSE_EN
            k_q     <= 4'd2;
            reuse_q <= 1'b1;
`else
            k_q     <= 4'd0;
            reuse_q <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
module tb_sobel_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  img_w = 8'd0;
  logic [7:0]  img_h = 8'd0;
  logic        rd_req, load_en, win_shift, calc_start, wr_req, busy, done;
  logic [15:0] rd_addr, wr_addr;
  logic [3:0]  win_idx;
  logic        rd_ack = 1'b0;
  logic        wr_ack = 1'b0;
  logic        calc_done = 1'b0;

  sobel_scan_ctrl #(.CNT_W(8), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .load_en(load_en), .win_idx(win_idx), .win_shift(win_shift),
    .calc_start(calc_start), .calc_done(calc_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  idx;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  logic [15:0] wr_q[$];

  int checks = 0;
  int failures = 0;

  int exp_reads, exp_writes, exp_ws, exp_cyc;
  int rd_dly = 0, wr_dly = 0;
  int cyc = 0, start_lbl = 0, done_lbl = 0;
  int mon_reads, mon_writes, mon_done, mon_ws, mon_calc, mon_rdreq_cyc, mon_wrreq_cyc;
  logic cs_seen = 1'b0;
  logic prev_rd_wait = 1'b0, prev_wr_wait = 1'b0;
  logic [15:0] prev_rd_addr, prev_wr_addr;
  logic [3:0]  prev_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference scan: every interior pixel in raster order.
  task automatic build_expect(input int w, input int h);
    rd_exp_t e;
    bit reuse;
    int n;
    rd_q.delete();
    wr_q.delete();
    exp_reads = 0; exp_writes = 0; exp_ws = 0; exp_cyc = 1;
    if (w >= 3 && h >= 3) begin
      for (int r = 1; r <= h - 2; r++) begin
        for (int c = 1; c <= w - 2; c++) begin
          reuse = 1'b0;
`ifdef SCAN_COL_REUSE_EN
          reuse = (c > 1);
`endif
          n = 0;
          for (int k = 0; k < 9; k++) begin
            if (!reuse || (k % 3 == 2)) begin
              e.addr = 16'((r + k / 3 - 1) * w + (c + k % 3 - 1));
              e.idx  = 4'(k);
              rd_q.push_back(e);
              n++;
            end
          end
          wr_q.push_back(16'((r - 1) * (w - 2) + (c - 1)));
          exp_reads += n;
          exp_writes++;
          if (reuse) exp_ws++;
          exp_cyc += n + 4;
        end
      end
    end
  endtask

  // Responder: acks after a programmable number of wait cycles; calc_done one cycle after calc_start.
  initial begin
    int rw, ww;
    rw = 0; ww = 0;
    forever begin
      @(posedge clk);
      #1;
      calc_done = cs_seen;
      cs_seen = 1'b0;
      if (rd_req) begin
        if (rw >= rd_dly) begin rd_ack = 1'b1; rw = 0; end
        else begin rd_ack = 1'b0; rw++; end
      end else begin
        rd_ack = 1'b0; rw = 0;
      end
      if (wr_req) begin
        if (ww >= wr_dly) begin wr_ack = 1'b1; ww = 0; end
        else begin wr_ack = 1'b0; ww++; end
      end else begin
        wr_ack = 1'b0; ww = 0;
      end
    end
  end

  // Monitor: scoreboard pops, hold stability and pulse counts, sampled on the falling edge.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      check("load_en", load_en, rd_req & rd_ack);
      if (rd_req) begin
        mon_rdreq_cyc++;
        if (prev_rd_wait) begin
          check("rd_addr_hold", rd_addr, prev_rd_addr);
          check("win_idx_hold", win_idx, prev_idx);
        end
        if (rd_ack) begin
          mon_reads++;
          check("rd_q_nonempty", rd_q.size() != 0, 1);
          if (rd_q.size() != 0) begin
            e = rd_q.pop_front();
            check("rd_addr", rd_addr, e.addr);
            check("win_idx", win_idx, e.idx);
          end
        end
        prev_rd_wait = !rd_ack;
        prev_rd_addr = rd_addr;
        prev_idx = win_idx;
      end else begin
        prev_rd_wait = 1'b0;
      end
      if (wr_req) begin
        mon_wrreq_cyc++;
        if (prev_wr_wait) check("wr_addr_hold", wr_addr, prev_wr_addr);
        if (wr_ack) begin
          mon_writes++;
          check("wr_q_nonempty", wr_q.size() != 0, 1);
          if (wr_q.size() != 0) check("wr_addr", wr_addr, wr_q.pop_front());
        end
        prev_wr_wait = !wr_ack;
        prev_wr_addr = wr_addr;
      end else begin
        prev_wr_wait = 1'b0;
      end
      if (win_shift) begin
        mon_ws++;
        check("win_shift_no_req", rd_req | wr_req, 0);
      end
      if (calc_start) begin
        mon_calc++;
        cs_seen = 1'b1;
      end
      if (done) begin
        mon_done++;
        done_lbl = cyc;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"},
          {rd_req, load_en, win_shift, calc_start, wr_req, busy, done}, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_win_idx"}, win_idx, 0);
  endtask

  task automatic start_frame(input int w, input int h);
    img_w = 8'(w);
    img_h = 8'(h);
    build_expect(w, h);
    mon_reads = 0; mon_writes = 0; mon_done = 0; mon_ws = 0; mon_calc = 0;
    mon_rdreq_cyc = 0; mon_wrreq_cyc = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    start_lbl = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("rd_req_after_start", rd_req, (w >= 3 && h >= 3) ? 1 : 0);
  endtask

  task automatic wait_done(input int exp_cycles);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (mon_done != 0) break;
    end
    repeat (2) @(posedge clk);
    #1;
    check("done_pulses", mon_done, 1);
    check("busy_after_done", busy, 0);
    check("reads", mon_reads, exp_reads);
    check("writes", mon_writes, exp_writes);
    check("rd_q_left", rd_q.size(), 0);
    check("wr_q_left", wr_q.size(), 0);
    check("win_shift_cnt", mon_ws, exp_ws);
    check("calc_cnt", mon_calc, exp_writes);
    check("no_rd_req_iff_empty", mon_rdreq_cyc == 0, exp_reads == 0);
    check("no_wr_req_iff_empty", mon_wrreq_cyc == 0, exp_writes == 0);
    if (exp_cycles > 0) check("frame_cycles", done_lbl - start_lbl, exp_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("idle");

    // Basic 4x4 frame, immediate acks.
    rd_dly = 0; wr_dly = 0;
    start_frame(4, 4);
    wait_done(exp_cyc);

    // Backpressure on both ports, same frame.
    rd_dly = 3; wr_dly = 2;
    start_frame(4, 4);
    wait_done(0);

    // Wider, non-square frame.
    rd_dly = 0; wr_dly = 0;
    start_frame(6, 5);
    wait_done(exp_cyc);

    // Degenerate size: no requests at all.
    start_frame(2, 5);
    wait_done(0);

    // Reset during the fetch of pixel 2.
    start_frame(4, 4);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (mon_writes == 1 && rd_req) break;
    end
    check("reached_pixel2_fetch", rd_req & (mon_writes == 1), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("mid_reset");
    rst = 1'b0;
    rd_q.delete();
    wr_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("no_done_after_reset", mon_done, 0);
    check("idle_after_reset", busy, 0);
    start_frame(4, 4);
    wait_done(exp_cyc);

    // start pulsed while busy with a different width: must be ignored.
    start_frame(4, 4);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (mon_calc != 0) break;
    end
    img_w = 8'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(exp_cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
